// File: rtl/iob_ibus_line_buf_pkg.sv
// Shared types and field-width helpers for the single-line instruction buffer.
package iob_ibus_line_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic int idx_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_words);
        return addr_w - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/iob_ibus_line_store.sv
// Line data array: one synchronous write port, one asynchronous read port.
module iob_ibus_line_store #(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] words [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (we) words[widx] <= wdata;
    end

    assign rdata = words[ridx];

endmodule

// File: rtl/iob_ibus_line_buf.sv
// Single-line read-only instruction buffer between CPU fetch bus and memory.
// Optional IOB_IBUS_LINE_BUF_STATS_EN adds saturating hit/miss counters.
//
// state | meaning
// IDLE  | ready for a CPU request; hit/miss decided on acceptance
// REQ   | memory request for word cnt held until m_ready_i
// WAIT  | waiting for the memory word of the current request
// RESP  | one-cycle answer to the CPU from the line
module iob_ibus_line_buf
    import iob_ibus_line_buf_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              flush_i,
    input  logic              s_avalid_i,
    input  logic [ADDR_W-1:0] s_addr_i,
    output logic              s_ready_o,
    output logic              s_rvalid_o,
    output logic [DATA_W-1:0] s_rdata_o,
    output logic              m_avalid_o,
    output logic [ADDR_W-1:0] m_addr_o,
    input  logic              m_ready_i,
    input  logic              m_rvalid_i,
    input  logic [DATA_W-1:0] m_rdata_i
`ifdef IOB_IBUS_LINE_BUF_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int IDX_W = idx_w(LINE_WORDS);
    localparam int TAG_W = tag_w(ADDR_W, LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    state_t            state;
    logic              line_valid;
    logic              pend_flush;
    logic [TAG_W-1:0]  tag_r;
    logic [IDX_W-1:0]  cnt;
    logic [IDX_W-1:0]  req_idx;
    logic              s_ready_r;
    logic              s_rvalid_r;
    logic              m_avalid_r;
    logic [DATA_W-1:0] line_rdata;

    logic [TAG_W-1:0]  s_tag;
    logic [IDX_W-1:0]  s_idx;
    logic              is_hit;
    logic              accept;
    logic              fill_we;
    logic              unused_byte_bits;

    assign s_tag   = s_addr_i[ADDR_W-1:IDX_W+2];
    assign s_idx   = s_addr_i[IDX_W+1:2];
    assign unused_byte_bits = ^s_addr_i[1:0];
    // A flush in the same cycle as a request forces the miss path.
    assign is_hit  = line_valid && !flush_i && (tag_r == s_tag);
    assign accept  = cke_i && (state == ST_IDLE) && s_avalid_i;
    assign fill_we = cke_i && (state == ST_WAIT) && m_rvalid_i;

    iob_ibus_line_store #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W)
    ) u_store (
        .clk   (clk_i),
        .we    (fill_we),
        .widx  (cnt),
        .wdata (m_rdata_i),
        .ridx  (req_idx),
        .rdata (line_rdata)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state      <= ST_IDLE;
            line_valid <= 1'b0;
            pend_flush <= 1'b0;
            tag_r      <= '0;
            cnt        <= '0;
            req_idx    <= '0;
            s_ready_r  <= 1'b1;
            s_rvalid_r <= 1'b0;
            m_avalid_r <= 1'b0;
        end else if (cke_i) begin
            s_rvalid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_avalid_i) begin
                        req_idx   <= s_idx;
                        s_ready_r <= 1'b0;
                        if (is_hit) begin
                            state      <= ST_RESP;
                            s_rvalid_r <= 1'b1;
                        end else begin
                            line_valid <= 1'b0;
                            tag_r      <= s_tag;
                            cnt        <= '0;
                            state      <= ST_REQ;
                            m_avalid_r <= 1'b1;
                        end
                    end else if (flush_i) begin
                        line_valid <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (flush_i) pend_flush <= 1'b1;
                    if (m_ready_i) begin
                        state      <= ST_WAIT;
                        m_avalid_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (flush_i) pend_flush <= 1'b1;
                    if (m_rvalid_i) begin
                        if (cnt == LAST_IDX) begin
                            line_valid <= ~(pend_flush | flush_i);
                            pend_flush <= 1'b0;
                            state      <= ST_RESP;
                            s_rvalid_r <= 1'b1;
                        end else begin
                            cnt        <= cnt + 1'b1;
                            state      <= ST_REQ;
                            m_avalid_r <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (flush_i) line_valid <= 1'b0;
                    state     <= ST_IDLE;
                    s_ready_r <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready_o  = s_ready_r;
    assign s_rvalid_o = s_rvalid_r;
    assign s_rdata_o  = s_rvalid_r ? line_rdata : '0;
    assign m_avalid_o = m_avalid_r;
    assign m_addr_o   = m_avalid_r ? {tag_r, cnt, 2'b00} : '0;

`ifdef IOB_IBUS_LINE_BUF_STATS_EN
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (accept) begin
            if (is_hit) begin
                if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
            end else begin
                if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iob_ibus_line_buf.sv
// Randomized self-checking bench for iob_ibus_line_buf against a line-level reference model.
module tb_iob_ibus_line_buf;

    localparam int LW = 4;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic        cke_i;
    logic        flush_i;
    logic        s_avalid_i;
    logic [31:0] s_addr_i;
    logic        s_ready_o;
    logic        s_rvalid_o;
    logic [31:0] s_rdata_o;
    logic        m_avalid_o;
    logic [31:0] m_addr_o;
    logic        m_ready_i;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;
`ifdef IOB_IBUS_LINE_BUF_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    iob_ibus_line_buf #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .cke_i      (cke_i),
        .flush_i    (flush_i),
        .s_avalid_i (s_avalid_i),
        .s_addr_i   (s_addr_i),
        .s_ready_o  (s_ready_o),
        .s_rvalid_o (s_rvalid_o),
        .s_rdata_o  (s_rdata_o),
        .m_avalid_o (m_avalid_o),
        .m_addr_o   (m_addr_o),
        .m_ready_i  (m_ready_i),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i)
`ifdef IOB_IBUS_LINE_BUF_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // reference model: one line of LW words, tagged by addr[31:4]
    bit          mv;
    logic [27:0] mtag;
    logic [31:0] mdata [LW];
    logic [31:0] seed;
    int          exp_hits;
    int          exp_misses;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic chk_stats();
`ifdef IOB_IBUS_LINE_BUF_STATS_EN
        chk("hit_cnt", hit_cnt_o, 32'(exp_hits));
        chk("miss_cnt", miss_cnt_o, 32'(exp_misses));
`endif
    endtask

    task automatic drive_idle();
        cke_i      = 1'b1;
        flush_i    = 1'b0;
        s_avalid_i = 1'b0;
        m_ready_i  = 1'b0;
        m_rvalid_i = 1'b0;
        m_rdata_i  = $urandom;
    endtask

    // One CPU read. Called at a negedge with the DUT idle. fw>=0 fixes memory delays;
    // flush_at>0 pulses flush_i when the flush_at-th memory request appears.
    task automatic do_read(input logic [31:0] addr, input bit flush_req,
                           input int flush_at, input int fw, input bit rnd);
        logic [31:0] base, stable, acc, expd;
        int  idx, nreq, k, k_last, rwait, rdel;
        bit  exp_hit, flushed, open, pend, done, cke_prev;

        base    = {addr[31:4], 4'h0};
        idx     = int'(addr[3:2]);
        exp_hit = mv && (mtag == addr[31:4]) && !flush_req;
        expd    = exp_hit ? mdata[idx] : memw(base + 32'(4 * idx));
        chk("ready_idle", {31'd0, s_ready_o}, 32'd1);

        drive_idle();
        s_avalid_i = 1'b1;
        s_addr_i   = addr | 32'($urandom_range(0, 3));
        flush_i    = flush_req;
        m_rvalid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;

        k = 0; k_last = -1; nreq = 0; rwait = 0; rdel = 0;
        open = 0; pend = 0; done = 0; flushed = 0; cke_prev = 1; stable = '0; acc = '0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk_i);
            if (cke_prev) k++;
            drive_idle();
            if (s_rvalid_o) begin
                chk("rv_latency", 32'(k), exp_hit ? 32'd1 : 32'(k_last));
                chk("rdata", s_rdata_o, expd);
                chk("mem_reqs", 32'(nreq), exp_hit ? 32'd0 : 32'(LW));
                done = 1;
            end else begin
                bit new_req;
                new_req = 0;
                if (m_avalid_o) begin
                    if (!open) begin
                        chk("m_addr", m_addr_o, base + 32'(4 * nreq));
                        if (nreq == 0) chk("m_first_lat", 32'(k), 32'd1);
                        open   = 1;
                        stable = m_addr_o;
                        rwait  = fw >= 0 ? fw : $urandom_range(0, 2);
                        nreq++;
                        new_req = 1;
                    end else begin
                        chk("m_addr_hold", m_addr_o, stable);
                    end
                end else if (open) begin
                    chk("m_avalid_drop", 32'd0, 32'd1);
                    open = 0;
                end
                cke_i = !rnd || ($urandom_range(0, 7) != 0);
                if (new_req && nreq == flush_at) begin
                    cke_i   = 1'b1;
                    flush_i = 1'b1;
                    flushed = 1;
                end
                if (cke_i) begin
                    if (open) begin
                        if (rwait == 0) begin
                            m_ready_i = 1'b1;
                            open = 0;
                            pend = 1;
                            acc  = stable;
                            rdel = fw >= 0 ? fw : $urandom_range(0, 2);
                        end else begin
                            rwait--;
                        end
                    end else if (pend) begin
                        if (rdel == 0) begin
                            m_rvalid_i = 1'b1;
                            m_rdata_i  = memw(acc);
                            pend   = 0;
                            k_last = k + 1;
                        end else begin
                            rdel--;
                        end
                    end else if (rnd) begin
                        m_rvalid_i = 1'($urandom_range(0, 1));
                    end
                    if (rnd && $urandom_range(0, 5) == 0) begin
                        s_avalid_i = 1'b1;
                        s_addr_i   = $urandom;
                    end
                end
            end
            cke_prev = cke_i;
        end
        if (!done) chk("timeout", 32'd0, 32'd1);

        @(negedge clk_i);
        chk("rv_one_cycle", {31'd0, s_rvalid_o}, 32'd0);
        chk("rdata_zero", s_rdata_o, 32'd0);
        chk("ready_back", {31'd0, s_ready_o}, 32'd1);

        if (exp_hit) begin
            exp_hits++;
        end else begin
            exp_misses++;
            mv   = !flushed;
            mtag = addr[31:4];
            for (int i = 0; i < LW; i++) mdata[i] = memw(base + 32'(4 * i));
        end
        chk_stats();
    endtask

    task automatic flush_idle();
        drive_idle();
        flush_i = 1'b1;
        @(negedge clk_i);
        drive_idle();
        mv = 0;
    endtask

    initial begin
        logic [31:0] a;
        seed = 32'h1234_5678;
        mv = 0; mtag = '0; exp_hits = 0; exp_misses = 0;
        for (int i = 0; i < LW; i++) mdata[i] = '0;
        arst_n_i = 1'b0;
        s_addr_i = '0;
        drive_idle();
        repeat (3) @(negedge clk_i);
        arst_n_i = 1'b1;
        @(negedge clk_i);

        chk("rst_s_ready", {31'd0, s_ready_o}, 32'd1);
        chk("rst_m_avalid", {31'd0, m_avalid_o}, 32'd0);
        chk("rst_s_rvalid", {31'd0, s_rvalid_o}, 32'd0);
        chk("rst_s_rdata", s_rdata_o, 32'd0);
        chk("rst_m_addr", m_addr_o, 32'd0);
        chk_stats();

        do_read(32'h108, 0, 0, 2, 0);   // cold miss, A2 returned
        do_read(32'h10C, 0, 0, -1, 0);  // hit, A3
        do_read(32'h200, 0, 0, -1, 0);
        do_read(32'h104, 0, 0, -1, 0);  // refill of 0x100
        do_read(32'h400, 0, 0, 3, 0);   // m_ready_i low for 3 cycles per request

        // flush mid-fill: data still returned, line left invalid
        arst_n_i = 1'b0;
        #1;
        arst_n_i = 1'b1;
        mv = 0; exp_hits = 0; exp_misses = 0;
        @(negedge clk_i);
        do_read(32'h300, 0, 2, -1, 0);
        do_read(32'h300, 0, 0, -1, 0);
        chk("flush_hits", 32'(exp_hits), 32'd0);
        do_read(32'h304, 0, 0, -1, 0);  // line now valid -> hit

        flush_idle();
        do_read(32'h308, 0, 0, -1, 0);  // must miss after idle flush
        do_read(32'h308, 1, 0, -1, 0);  // flush with request -> miss
        do_read(32'h30C, 0, 0, -1, 0);  // line valid after that fill

        // reset during a fill
        drive_idle();
        s_avalid_i = 1'b1;
        s_addr_i   = 32'h500;
        @(negedge clk_i);
        drive_idle();
        repeat (2) @(negedge clk_i);
        chk("pre_rst_m_avalid", {31'd0, m_avalid_o}, 32'd1);
        arst_n_i = 1'b0;
        #1;
        chk("arst_m_avalid", {31'd0, m_avalid_o}, 32'd0);
        chk("arst_s_ready", {31'd0, s_ready_o}, 32'd1);
        chk("arst_s_rvalid", {31'd0, s_rvalid_o}, 32'd0);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        mv = 0; exp_hits = 0; exp_misses = 0;
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk_i);
        drive_idle();
        chk("late_rv_m_avalid", {31'd0, m_avalid_o}, 32'd0);
        chk("late_rv_s_rvalid", {31'd0, s_rvalid_o}, 32'd0);
        do_read(32'h500, 0, 0, -1, 0);

        for (int t = 0; t < 60; t++) begin
            a = {20'd0, 4'($urandom_range(1, 4)), 8'd0} | {28'd0, 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 9) == 0) flush_idle();
            if ($urandom_range(0, 9) == 0 && !mv) seed = $urandom;
            do_read(a, $urandom_range(0, 11) == 0,
                    ($urandom_range(0, 5) == 0) ? $urandom_range(1, LW) : 0, -1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
